// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Accepts parallel words over a valid/ready handshake and shifts them out
// MSB-first. A programmable pattern is matched on the serial stream, with
// overlapping matches allowed. Matches are counted with saturation, and a
// sticky irq is raised when the count reaches a programmed threshold.
module seq_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq,
    input  logic              irq_clr
);

    localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SEEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [WORD_W-1:0]   sreg_reg;
    logic [BC_W-1:0]     bitcnt_reg;
    logic [PAT_W-1:0]    hist_reg;
    logic [SEEN_W-1:0]   seen_reg;
    logic [PAT_W-1:0]    pat_q_reg;
    logic [CNT_W-1:0]    thr_q_reg;
    logic                match_pulse_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                irq_reg;

    // Derived per-cycle datapath terms
    logic                shifting;
    logic                session_start;
    logic                word_load;
    logic [PAT_W-1:0]    new_hist;
    logic [SEEN_W:0]     seen_plus;
    logic [SEEN_W-1:0]   seen_next;
    logic                hit;
    logic [CNT_W:0]      count_plus;
    logic                count_full;
    logic                thr_hit;

    // Bit-level match evaluation for the bit currently on bit_out
    always_comb begin
        shifting      = (state_reg == S_SHIFT);
        // start is ignored in IDLE only when not offered; in DONE a
        // simultaneous stop takes priority over start.
        session_start = ((state_reg == S_IDLE) && start) ||
                        ((state_reg == S_DONE) && start && !stop);
        word_load     = (state_reg == S_WAIT) && in_valid && !stop;
        new_hist      = {hist_reg[PAT_W-2:0], sreg_reg[WORD_W-1]};
        seen_plus     = {1'b0, seen_reg} + 1'b1;
        seen_next     = (seen_reg == SEEN_W'(PAT_W)) ? seen_reg : seen_plus[SEEN_W-1:0];
        // A match needs PAT_W real stream bits, so the cleared history
        // cannot produce a spurious hit at the start of a session.
        hit           = shifting && (new_hist == pat_q_reg) &&
                        (seen_plus >= (SEEN_W+1)'(PAT_W));
        count_plus    = {1'b0, count_reg} + 1'b1;
        count_full    = &count_reg;
        thr_hit       = hit && (thr_q_reg != '0) && (count_plus == {1'b0, thr_q_reg});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (stop)          state_next = S_IDLE;
                else if (in_valid) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (stop)                    state_next = S_IDLE;
                else if (thr_hit)            state_next = S_DONE;
                else if (bitcnt_reg == '0)   state_next = S_WAIT;
            end
            S_DONE: begin
                if (stop)       state_next = S_IDLE;
                else if (start) state_next = S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs and registered status outputs
    always_comb begin
        in_ready    = (state_reg == S_WAIT);
        busy        = (state_reg == S_WAIT) || (state_reg == S_SHIFT);
        bit_valid   = (state_reg == S_SHIFT);
        bit_out     = sreg_reg[WORD_W-1];
        match_pulse = match_pulse_reg;
        match_count = count_reg;
        irq         = irq_reg;
    end

    // Shift register, match history, counters and sticky irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_reg        <= '0;
            bitcnt_reg      <= '0;
            hist_reg        <= '0;
            seen_reg        <= '0;
            pat_q_reg       <= '0;
            thr_q_reg       <= '0;
            match_pulse_reg <= 1'b0;
            count_reg       <= '0;
            irq_reg         <= 1'b0;
        end else begin
            match_pulse_reg <= hit;

            if (session_start) begin
                pat_q_reg <= cfg_pattern;
                thr_q_reg <= cfg_thresh;
                hist_reg  <= '0;
                seen_reg  <= '0;
                count_reg <= '0;
            end

            if (word_load) begin
                sreg_reg   <= in_data;
                bitcnt_reg <= BC_W'(WORD_W - 1);
            end

            // History and seen persist across words so matches can span
            // word boundaries; the shift still completes on a stop edge.
            if (shifting) begin
                hist_reg   <= new_hist;
                seen_reg   <= seen_next;
                sreg_reg   <= sreg_reg << 1;
                bitcnt_reg <= bitcnt_reg - 1'b1;
                if (hit && !count_full) begin
                    count_reg <= count_plus[CNT_W-1:0];
                end
            end

            // Setting takes priority over a simultaneous clear
            if (thr_hit) begin
                irq_reg <= 1'b1;
            end else if (irq_clr) begin
                irq_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: single words, overlap, cross-word
// matches, threshold/irq, abort, asynchronous reset and count saturation.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_thresh;
    logic       in_valid;
    logic [7:0] in_data;
    logic       irq_clr;

    logic       in_ready, busy, bit_out, bit_valid, match_pulse, irq;
    logic [7:0] match_count;

    logic       in_ready_s, busy_s, bit_out_s, bit_valid_s, match_pulse_s, irq_s;
    logic [1:0] match_count_s;

    int errors = 0;
    int checks = 0;

    seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_pattern (cfg_pattern),
        .cfg_thresh  (cfg_thresh),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .irq         (irq),
        .irq_clr     (irq_clr)
    );

    // Narrow-counter instance for the saturation case
    seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_pattern (cfg_pattern),
        .cfg_thresh  (cfg_thresh[1:0]),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready_s),
        .busy        (busy_s),
        .bit_out     (bit_out_s),
        .bit_valid   (bit_valid_s),
        .match_pulse (match_pulse_s),
        .match_count (match_count_s),
        .irq         (irq_s),
        .irq_clr     (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Return to IDLE, then start a session with the given configuration
    task automatic begin_session(input logic [3:0] pat, input logic [7:0] thr);
        cfg_pattern = pat;
        cfg_thresh  = thr;
        stop = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one word and record match_pulse after each of its 8 bits
    // (pulses[k-1] holds the pulse produced by bit k)
    task automatic send_word(input logic [7:0] data, output logic [7:0] pulses);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pulses[k] = match_pulse;
        end
    endtask

    logic [7:0] p;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; cfg_pattern = '0; cfg_thresh = '0;
        repeat (2) @(negedge clk);
        check("reset_flags", {in_ready, busy, bit_out, bit_valid, match_pulse, irq}, 0);
        check("reset_count", match_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_flags", {in_ready, busy, bit_valid}, 0);

        // T1: pattern 1100, single word CC
        begin_session(4'b1100, 8'd0);
        check("t1_wait_ready", {in_ready, busy}, 2'b11);
        send_word(8'hCC, p);
        check("t1_pulses", p, 8'h88);
        check("t1_count", match_count, 2);
        check("t1_irq", irq, 0);

        // T2: overlapping matches of 1010 in AA
        begin_session(4'b1010, 8'd0);
        send_word(8'hAA, p);
        check("t2_pulses", p, 8'hA8);
        check("t2_count", match_count, 3);

        // T3: match spanning the 03 / 00 word boundary
        begin_session(4'b1100, 8'd0);
        send_word(8'h03, p);
        check("t3_pulses_w1", p, 8'h00);
        send_word(8'h00, p);
        check("t3_pulses_w2", p, 8'h02);
        check("t3_count", match_count, 1);

        // T4: threshold 2 reached on bit 8 of the first word
        begin_session(4'b1100, 8'd2);
        send_word(8'hCC, p);
        check("t4_pulses", p, 8'h88);
        check("t4_irq_set", irq, 1);
        check("t4_done_flags", {in_ready, busy}, 2'b00);
        check("t4_count", match_count, 2);
        send_word(8'hCC, p);
        check("t4_ignored_pulses", p, 8'h00);
        check("t4_count_held", match_count, 2);
        check("t4_irq_sticky", irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("t4_irq_clr", irq, 0);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        check("t4_stop_beats_start", {in_ready, busy}, 2'b00);
        check("t4_count_in_idle", match_count, 2);

        // T5a: stop on the same edge as the bit-4 hit
        begin_session(4'b1100, 8'd0);
        in_valid = 1'b1; in_data = 8'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_shifting", bit_valid, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_stop_idle", {busy, bit_valid, in_ready}, 0);
        check("t5_stop_hit_pulse", match_pulse, 1);
        check("t5_stop_count", match_count, 1);
        @(negedge clk);
        check("t5_count_retained", match_count, 1);
        check("t5_pulse_drop", match_pulse, 0);

        // T5b: asynchronous reset in the middle of a word
        begin_session(4'b1100, 8'd0);
        in_valid = 1'b1; in_data = 8'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_pre_rst", {busy, bit_out, match_count}, {1'b1, 1'b1, 8'd1});
        #2 rst = 1'b1;
        #1;
        check("t5_rst_flags", {in_ready, busy, bit_out, bit_valid, match_pulse, irq}, 0);
        check("t5_rst_count", match_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T6: saturation on the 2-bit counter, full count on the 8-bit one
        begin_session(4'b1010, 8'd0);
        send_word(8'hAA, p);
        check("t6_sat_count_w1", match_count_s, 3);
        send_word(8'hAA, p);
        check("t6_pulses_w2", p, 8'hAA);
        check("t6_wide_count", match_count, 7);
        check("t6_sat_count", match_count_s, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
